uart_rx: RTL and testbench

Receive half of the 8-N-1 UART. Consumes the 16× oversampling `rx_sample_tick` from the baud tick generator, synchronizes the asynchronous `rxd` line and validates the start bit at mid-bit. Samples 8 data bits LSB-first and checks the stop bit. Presents each received byte on a valid/ready handshake to the CTRL/CSR logic, with framing and overrun error pulses.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 23 ++
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive and transmit halves.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous level; resets to 1 (idle-high lines).
module uart_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_50mhz,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8-N-1 UART receiver: oversampled mid-bit sampling, valid/ready byte output,
// framing and overrun error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk_50mhz,
  input  logic                 rst_n,
  input  logic                 rx_sample_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 rx_busy
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  logic                 rxd_s;
  uart_rx_state_t       state_q;
  logic                 armed_q;
  logic [CntW-1:0]      cnt_q;
  logic [BitW-1:0]      bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;

  uart_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rxd_sync (
    .clk_50mhz(clk_50mhz),
    .rst_n    (rst_n),
    .async_in (rxd),
    .sync_out (rxd_s)
  );

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (rx_sample_tick) begin
        unique case (state_q)
          IDLE: begin
            // A falling edge only counts once the line has been seen high.
            if (!armed_q) begin
              armed_q <= rxd_s;
            end else if (!rxd_s) begin
              cnt_q   <= '0;
              state_q <= START;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (cnt_q == CntHalf) begin
              cnt_q     <= '0;
              bit_idx_q <= '0;
              if (rxd_s) begin
                state_q <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state_q <= DATA;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DATA: begin
            cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
              if (bit_idx_q == BitLast) begin
                bit_idx_q <= '0;
                state_q   <= STOP;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
              end
            end
          end
          STOP: begin
            cnt_q <= (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= IDLE;
              rx_busy <= 1'b0;
              // A low stop bit leaves us unarmed so a held break reports once.
              armed_q <= rxd_s;
              if (!rxd_s) begin
                frame_err <= 1'b1;
              end else if (!rx_valid || rx_ready) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            rx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table plus hand-written corner sequences,
// with a byte scoreboard drained on every valid/ready handshake.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned OS        = UART_OVERSAMPLE;
  localparam int unsigned DB        = UART_DATA_BITS;
  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned BIT_CLKS  = OS * TICK_DIV;
  localparam int          STOP_TICK = OS / 2 + OS * (DB + 1);

  logic          clk_50mhz = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_sample_tick = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun_err;
  logic          rx_busy;

  uart_rx dut (
    .clk_50mhz     (clk_50mhz),
    .rst_n         (rst_n),
    .rx_sample_tick(rx_sample_tick),
    .rxd           (rxd),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .frame_err     (frame_err),
    .overrun_err   (overrun_err),
    .rx_busy       (rx_busy)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // One tick every TICK_DIV clocks; s2 mirrors the two-flop synchronizer output.
  logic [1:0] div_q = 2'd0;
  logic       s1 = 1'b1;
  logic       s2 = 1'b1;
  always @(posedge clk_50mhz) begin
    div_q          <= div_q + 2'd1;
    rx_sample_tick <= (div_q == 2'd3);
    s1             <= rxd;
    s2             <= s1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard and event counters, sampled on the falling edge.
  logic [DB-1:0] sb_q[$];
  logic [DB-1:0] sb_exp;
  int            valid_rise = 0;
  int            busy_rise  = 0;
  int            ferr_cnt   = 0;
  int            ovr_cnt    = 0;
  logic          valid_prev = 1'b0;
  logic          busy_prev  = 1'b0;

  always @(negedge clk_50mhz) begin
    if (rst_n) begin
      if (rx_valid && rx_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_unexpected: got %02h, expected no byte", rx_data);
        end else begin
          sb_exp = sb_q.pop_front();
          check("sb_data", 32'(rx_data), 32'(sb_exp));
        end
      end
      if (frame_err) ferr_cnt++;
      if (overrun_err) ovr_cnt++;
      if (rx_valid && !valid_prev) valid_rise++;
      if (rx_busy && !busy_prev) busy_rise++;
    end
    valid_prev = rx_valid;
    busy_prev  = rx_busy;
  end

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    int            exp_valid;
    int            exp_ferr;
  } vec_t;

  vec_t vecs[5];
  int   b_v, b_f, b_o, b_b;
  int   n_tick;
  bit   hit;

  initial begin
    repeat (100000) @(posedge clk_50mhz);
    $display("FAIL watchdog: got no finish, expected finish within 100000 clocks");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h96, 1'b1, 1, 0};

    wait_clks(5);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun_err), 32'h0);
    check("rst_busy", 32'(rx_busy), 32'h0);
    rst_n = 1'b1;
    wait_clks(BIT_CLKS);

    for (int k = 0; k < 5; k++) begin
      b_v = valid_rise; b_f = ferr_cnt; b_o = ovr_cnt;
      if (vecs[k].stop) sb_q.push_back(vecs[k].data);
      send_frame(vecs[k].data, vecs[k].stop);
      rxd = 1'b1;
      wait_clks(2 * BIT_CLKS);
      check("tbl_valid", 32'(valid_rise - b_v), 32'(vecs[k].exp_valid));
      check("tbl_ferr", 32'(ferr_cnt - b_f), 32'(vecs[k].exp_ferr));
      check("tbl_ovr", 32'(ovr_cnt - b_o), 32'h0);
      check("tbl_sb_empty", 32'(sb_q.size()), 32'h0);
    end

    // Three-tick glitch is rejected at the mid-start check.
    b_v = valid_rise; b_f = ferr_cnt; b_b = busy_rise;
    rxd = 1'b0;
    wait_clks(3 * TICK_DIV);
    rxd = 1'b1;
    wait_clks(BIT_CLKS);
    check("glitch_busy_rose", 32'(busy_rise - b_b), 32'h1);
    check("glitch_busy_now", 32'(rx_busy), 32'h0);
    check("glitch_valid", 32'(valid_rise - b_v), 32'h0);
    check("glitch_ferr", 32'(ferr_cnt - b_f), 32'h0);

    // Framing error followed by a held break: one error only.
    b_v = valid_rise; b_f = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    wait_clks(3 * (DB + 2) * BIT_CLKS);
    check("break_ferr", 32'(ferr_cnt - b_f), 32'h1);
    check("break_valid", 32'(valid_rise - b_v), 32'h0);
    rxd = 1'b1;
    wait_clks(BIT_CLKS);
    sb_q.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    wait_clks(BIT_CLKS);
    check("after_break_valid", 32'(valid_rise - b_v), 32'h1);
    check("after_break_sb", 32'(sb_q.size()), 32'h0);
    check("after_break_ferr", 32'(ferr_cnt - b_f), 32'h1);

    // Overrun: second byte dropped while the first is held.
    rx_ready = 1'b0;
    b_o = ovr_cnt;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(BIT_CLKS);
    check("ovr_valid", 32'(rx_valid), 32'h1);
    check("ovr_data", 32'(rx_data), 32'h11);
    check("ovr_pulse", 32'(ovr_cnt - b_o), 32'h1);
    rx_ready = 1'b1;
    wait_clks(2);
    check("ovr_drain_valid", 32'(rx_valid), 32'h0);
    check("ovr_drain_sb", 32'(sb_q.size()), 32'h0);

    // Handshake lands exactly on the stop-sample cycle of the next byte.
    rx_ready = 1'b0;
    sb_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    wait_clks(BIT_CLKS);
    check("edge_first_valid", 32'(rx_valid), 32'h1);
    b_o = ovr_cnt; b_v = valid_rise;
    sb_q.push_back(8'h22);
    hit = 1'b0;
    n_tick = -1;
    fork
      send_frame(8'h22, 1'b1);
      begin
        for (int k = 0; k < 11 * BIT_CLKS && !hit; k++) begin
          @(posedge clk_50mhz);
          #1;
          if (rx_sample_tick) begin
            if (n_tick < 0) begin
              if (!s2) n_tick = 0;
            end else begin
              n_tick++;
              if (n_tick == STOP_TICK) begin
                rx_ready = 1'b1;
                @(posedge clk_50mhz);
                #1;
                rx_ready = 1'b0;
                hit = 1'b1;
              end
            end
          end
        end
      end
    join
    wait_clks(4);
    check("edge_found_stop", 32'(hit), 32'h1);
    check("edge_valid", 32'(rx_valid), 32'h1);
    check("edge_data", 32'(rx_data), 32'h22);
    check("edge_no_drop", 32'(valid_rise - b_v), 32'h0);
    check("edge_ovr", 32'(ovr_cnt - b_o), 32'h0);
    check("edge_sb_left", 32'(sb_q.size()), 32'h1);
    rx_ready = 1'b1;
    wait_clks(2);
    check("edge_drain_sb", 32'(sb_q.size()), 32'h0);

    // Asynchronous reset in the middle of data bit 4.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_clks(5 * BIT_CLKS + BIT_CLKS / 2);
        check("rstmid_busy_before", 32'(rx_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstmid_data", 32'(rx_data), 32'h0);
        check("rstmid_valid", 32'(rx_valid), 32'h0);
        check("rstmid_busy", 32'(rx_busy), 32'h0);
        check("rstmid_ferr", 32'(frame_err), 32'h0);
        check("rstmid_ovr", 32'(overrun_err), 32'h0);
        wait_clks(3);
        rst_n = 1'b1;
      end
    join
    rxd = 1'b1;
    wait_clks(BIT_CLKS);
    b_v = valid_rise; b_f = ferr_cnt;
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_clks(BIT_CLKS);
    check("post_rst_valid", 32'(valid_rise - b_v), 32'h1);
    check("post_rst_sb", 32'(sb_q.size()), 32'h0);
    check("post_rst_ferr", 32'(ferr_cnt - b_f), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
